mac_scheduler: RTL

//  Sequences the 4x4 signed MAC datapath for one GNN feature-transform pass.

---
 rtl/gnn_pkg.sv | 16 +
 rtl/res_fifo.sv | 51 +++++
 rtl/mac_scheduler.sv | 133 +++++++++++++
 3 files changed

// File: rtl/gnn_pkg.sv
// Shared types and default widths for the GNN feature-transform datapath.
package gnn_pkg;

    localparam int DEF_MAC_IN_SIZE  = 5;
    localparam int DEF_W_SIZE       = 5;
    localparam int DEF_MAC_OUT_SIZE = 13;
    localparam int DEF_ADDR_W       = 8;
    localparam int DEF_FIFO_DEPTH   = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } sched_state_e;

endpackage

// File: rtl/res_fifo.sv
// Synchronous result FIFO with occupancy count; storage clears on reset.
module res_fifo #(
    parameter int WIDTH = 60,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           wdata,
    input  logic                       pop,
    output logic [WIDTH-1:0]           rdata,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wp, rp;
    logic             full, do_push, do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rp];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < DEPTH; k++) mem[k] <= '0;
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                mem[wp] <= wdata;
                wp      <= wp + AW'(1);
            end
            if (do_pop) rp <= rp + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

    // The scheduler's credit check must make this impossible.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/mac_scheduler.sv
// Sequences feature reads through the 4x4 MAC and streams results out in node order.
//  state | meaning
//  IDLE  | waiting for start; weight writes accepted
//  RUN   | issuing feature reads while result credit is available
//  DRAIN | all reads issued; waiting for the last result to be accepted
module mac_scheduler
    import gnn_pkg::*;
#(
    parameter int MAC_IN_SIZE  = DEF_MAC_IN_SIZE,
    parameter int W_SIZE       = DEF_W_SIZE,
    parameter int MAC_OUT_SIZE = DEF_MAC_OUT_SIZE,
    parameter int ADDR_W       = DEF_ADDR_W,
    parameter int FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [ADDR_W:0]           num_nodes,
    output logic                      busy,
    output logic                      done,
    input  logic                      wcfg_we,
    input  logic [3:0]                wcfg_addr,
    input  logic [W_SIZE-1:0]         wcfg_data,
    output logic                      feat_rd_en,
    output logic [ADDR_W-1:0]         feat_addr,
    input  logic [4*MAC_IN_SIZE-1:0]  feat_rdata,
    output logic [4*MAC_IN_SIZE-1:0]  mac_x,
    output logic [16*W_SIZE-1:0]      mac_w,
    output logic                      mac_in_ready,
    input  logic                      mac_ready,
    input  logic [4*MAC_OUT_SIZE-1:0] mac_out,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [ADDR_W-1:0]         out_addr,
    output logic [4*MAC_OUT_SIZE-1:0] out_data
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int DW = ADDR_W + 4*MAC_OUT_SIZE;

    sched_state_e      state, state_nx;
    logic [ADDR_W:0]   rd_ptr, num_q;
    logic [W_SIZE-1:0] w_q [16];
    logic              v1, v2, zero_done;
    logic [ADDR_W-1:0] a1, a2;
    logic [CW-1:0]     fifo_count;
    logic [CW:0]       used;
    logic              fifo_empty, pop, issue, drain_exit;
    logic [DW-1:0]     fifo_rdata;

    // Credit counts both queued results and reads still travelling through the MAC.
    assign used = (CW+1)'(fifo_count) + (CW+1)'(v1) + (CW+1)'(v2);

    always_comb begin
        state_nx   = state;
        issue      = 1'b0;
        drain_exit = 1'b0;
        case (state)
            IDLE: if (start && num_nodes != '0) state_nx = RUN;
            RUN: begin
                issue = (used < (CW+1)'(FIFO_DEPTH));
                if (issue && (rd_ptr + (ADDR_W+1)'(1) == num_q)) state_nx = DRAIN;
            end
            DRAIN: begin
                drain_exit = !v1 && !v2 && (fifo_count == CW'(1)) && pop;
                if (drain_exit) state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            num_q     <= '0;
            v1        <= 1'b0;
            v2        <= 1'b0;
            a1        <= '0;
            a2        <= '0;
            zero_done <= 1'b0;
        end else begin
            state     <= state_nx;
            zero_done <= (state == IDLE) && start && (num_nodes == '0);
            if (state == IDLE && start) begin
                rd_ptr <= '0;
                num_q  <= num_nodes;
            end else if (issue) begin
                rd_ptr <= rd_ptr + (ADDR_W+1)'(1);
            end
            v1 <= issue;
            a1 <= rd_ptr[ADDR_W-1:0];
            v2 <= v1;
            a2 <= a1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 16; k++) w_q[k] <= '0;
        end else if (state == IDLE && wcfg_we) begin
            w_q[wcfg_addr] <= wcfg_data;
        end
    end

    always_comb begin
        mac_w = '0;
        for (int k = 0; k < 16; k++) mac_w[k*W_SIZE +: W_SIZE] = w_q[k];
    end

    assign busy         = (state != IDLE);
    assign done         = drain_exit || zero_done;
    assign feat_rd_en   = issue;
    assign feat_addr    = rd_ptr[ADDR_W-1:0];
    assign mac_x        = feat_rdata;
    assign mac_in_ready = v1;
    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && out_ready;
    assign out_addr     = fifo_rdata[DW-1 -: ADDR_W];
    assign out_data     = fifo_rdata[4*MAC_OUT_SIZE-1:0];

    res_fifo #(.WIDTH(DW), .DEPTH(FIFO_DEPTH)) u_res_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (mac_ready),
        .wdata ({a2, mac_out}),
        .pop   (pop),
        .rdata (fifo_rdata),
        .empty (fifo_empty),
        .count (fifo_count)
    );

endmodule
